// File: rtl/zion_dat_write_pkg.sv
// Shared helpers for the narrow-write packer: width derivation, lane masks
// and write legality checks.
package zion_dat_write_pkg;

  localparam int MAX_UNIT = 64;
  localparam int MAX_UNIT_W = $clog2(MAX_UNIT);

  function automatic int calc_num_unit(input int width_data, input int width_unit);
    return width_data / width_unit;
  endfunction

  function automatic int calc_width_addr(input int num_unit);
    return $clog2(num_unit);
  endfunction

  function automatic int calc_width_size(input int width_addr);
    return $clog2(width_addr + 1);
  endfunction

  // Units addr..addr+2^size-1, optionally mirrored so unit 0 lands in the top lane.
  function automatic logic [MAX_UNIT-1:0] lane_mask(input int unsigned addr,
                                                    input int unsigned size,
                                                    input int unsigned num_unit,
                                                    input bit addr_type);
    logic [MAX_UNIT-1:0] m;
    logic [MAX_UNIT_W-1:0] idx;
    int unsigned span;
    m = '0;
    span = (size < 31) ? (32'd1 << size) : 32'd0;
    for (int unsigned u = 0; u < MAX_UNIT; u++) begin
      if (u < num_unit && u >= addr && u < addr + span) begin
        idx = MAX_UNIT_W'(addr_type ? (num_unit - 1 - u) : u);
        m[idx] = 1'b1;
      end
    end
    return m;
  endfunction

  function automatic bit addr_legal(input int unsigned addr,
                                    input int unsigned size,
                                    input int unsigned width_addr);
    if (size > width_addr) return 1'b0;
    return (addr & ((32'd1 << size) - 32'd1)) == 32'd0;
  endfunction

endpackage

// File: rtl/zion_dat_write_merge.sv
// Combinational merge of one narrow write into the assembly buffer.
// Illegal writes pass the buffer through untouched.
module zion_dat_write_merge
  import zion_dat_write_pkg::*;
#(
  parameter int WIDTH_DATA_OUT = 32,
  parameter int WIDTH_UNIT = 8,
  parameter int ADDR_TYPE = 0,
  localparam int NUM_UNIT = calc_num_unit(WIDTH_DATA_OUT, WIDTH_UNIT),
  localparam int WIDTH_ADDR = calc_width_addr(NUM_UNIT),
  localparam int WIDTH_SIZE = calc_width_size(WIDTH_ADDR)
)(
  input  logic [WIDTH_DATA_OUT-1:0] buf_dat,
  input  logic [NUM_UNIT-1:0]       buf_mask,
  input  logic [WIDTH_ADDR-1:0]     wr_addr,
  input  logic [WIDTH_SIZE-1:0]     wr_size,
  input  logic [WIDTH_DATA_OUT-1:0] wr_dat,
  output logic [WIDTH_DATA_OUT-1:0] merged_dat,
  output logic [NUM_UNIT-1:0]       merged_mask,
  output logic                      legal
);

  logic [NUM_UNIT-1:0]       hit_lane;
  logic [WIDTH_DATA_OUT-1:0] shifted;

  always_comb begin
    legal    = addr_legal(32'(wr_addr), 32'(wr_size), WIDTH_ADDR);
    hit_lane = NUM_UNIT'(lane_mask(32'(wr_addr), 32'(wr_size), NUM_UNIT, ADDR_TYPE != 0));
    shifted  = wr_dat << (32'(wr_addr) * WIDTH_UNIT);
  end

  // shifted holds data in unit order; each unit u is routed to its physical lane.
  for (genvar u = 0; u < NUM_UNIT; u++) begin : g_unit
    localparam int LANE = (ADDR_TYPE != 0) ? (NUM_UNIT - 1 - u) : u;
    logic hit;
    assign hit = legal && hit_lane[LANE];
    assign merged_dat[LANE*WIDTH_UNIT +: WIDTH_UNIT] =
      hit ? shifted[u*WIDTH_UNIT +: WIDTH_UNIT] : buf_dat[LANE*WIDTH_UNIT +: WIDTH_UNIT];
    assign merged_mask[LANE] = hit | buf_mask[LANE];
  end

endmodule

// File: rtl/zion_dat_write_pack.sv
// Packs narrow unit-addressed writes into full-width words and emits them
// through a registered valid/ready slot.
module zion_dat_write_pack
  import zion_dat_write_pkg::*;
#(
  parameter int WIDTH_DATA_OUT = 32,
  parameter int WIDTH_UNIT = 8,
  parameter int ADDR_TYPE = 0,
  parameter int WIDTH_CNT = 16,
  localparam int NUM_UNIT = calc_num_unit(WIDTH_DATA_OUT, WIDTH_UNIT),
  localparam int WIDTH_ADDR = calc_width_addr(NUM_UNIT),
  localparam int WIDTH_SIZE = calc_width_size(WIDTH_ADDR)
)(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      iVld,
  output logic                      oRdy,
  input  logic [WIDTH_ADDR-1:0]     iAddr,
  input  logic [WIDTH_SIZE-1:0]     iSize,
  input  logic [WIDTH_DATA_OUT-1:0] iDat,
  input  logic                      iLast,
  output logic                      oVld,
  input  logic                      iRdy,
  output logic [WIDTH_DATA_OUT-1:0] oDat,
  output logic [NUM_UNIT-1:0]       oMask,
  output logic                      oErr,
  output logic [WIDTH_CNT-1:0]      oWordCnt
);

  logic [WIDTH_DATA_OUT-1:0] buf_dat_q, buf_dat_d;
  logic [NUM_UNIT-1:0]       buf_mask_q, buf_mask_d;
  logic                      out_vld_q, out_vld_d;
  logic [WIDTH_DATA_OUT-1:0] out_dat_q, out_dat_d;
  logic [NUM_UNIT-1:0]       out_mask_q, out_mask_d;
  logic                      err_q, err_d;
  logic [WIDTH_CNT-1:0]      cnt_q, cnt_d;

  logic [WIDTH_DATA_OUT-1:0] merged_dat;
  logic [NUM_UNIT-1:0]       merged_mask;
  logic                      legal;
  logic                      accept;
  logic                      xfer;
  logic                      complete;

  zion_dat_write_merge #(
    .WIDTH_DATA_OUT (WIDTH_DATA_OUT),
    .WIDTH_UNIT     (WIDTH_UNIT),
    .ADDR_TYPE      (ADDR_TYPE)
  ) u_merge (
    .buf_dat     (buf_dat_q),
    .buf_mask    (buf_mask_q),
    .wr_addr     (iAddr),
    .wr_size     (iSize),
    .wr_dat      (iDat),
    .merged_dat  (merged_dat),
    .merged_mask (merged_mask),
    .legal       (legal)
  );

  assign oRdy     = ~out_vld_q | iRdy;
  assign oVld     = out_vld_q;
  assign oDat     = out_dat_q;
  assign oMask    = out_mask_q;
  assign oErr     = err_q;
  assign oWordCnt = cnt_q;

  // A completing accept reloads the output slot in the same edge a transfer empties it.
  always_comb begin
    accept     = iVld & oRdy;
    xfer       = out_vld_q & iRdy;
    complete   = accept & ((&merged_mask) | (iLast & (|merged_mask)));
    buf_dat_d  = buf_dat_q;
    buf_mask_d = buf_mask_q;
    out_vld_d  = out_vld_q;
    out_dat_d  = out_dat_q;
    out_mask_d = out_mask_q;
    err_d      = accept & ~legal;
    cnt_d      = cnt_q + WIDTH_CNT'(xfer);

    if (xfer) begin
      out_vld_d = 1'b0;
    end
    if (complete) begin
      out_vld_d  = 1'b1;
      out_dat_d  = merged_dat;
      out_mask_d = merged_mask;
      buf_dat_d  = '0;
      buf_mask_d = '0;
    end else if (accept) begin
      buf_dat_d  = merged_dat;
      buf_mask_d = merged_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_dat_q  <= '0;
      buf_mask_q <= '0;
      out_vld_q  <= 1'b0;
      out_dat_q  <= '0;
      out_mask_q <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      buf_dat_q  <= buf_dat_d;
      buf_mask_q <= buf_mask_d;
      out_vld_q  <= out_vld_d;
      out_dat_q  <= out_dat_d;
      out_mask_q <= out_mask_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_zion_dat_write_pack.sv
// Bench for zion_dat_write_pack: two instances (lane orders 0 and 1) share
// stimulus and are compared every cycle against a per-unit array model.
module tb_zion_dat_write_pack;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iVld = 1'b0;
  logic [1:0]  iAddr = '0;
  logic [1:0]  iSize = '0;
  logic [31:0] iDat = '0;
  logic        iLast = 1'b0;
  logic        iRdy = 1'b0;

  logic [1:0]  o_rdy;
  logic [1:0]  o_vld;
  logic [1:0]  o_err;
  logic [31:0] o_dat [2];
  logic [3:0]  o_mask [2];
  logic [15:0] o_cnt [2];

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  zion_dat_write_pack #(.WIDTH_DATA_OUT(32), .WIDTH_UNIT(8), .ADDR_TYPE(0), .WIDTH_CNT(16)) dut0 (
    .clk(clk), .rst(rst), .iVld(iVld), .oRdy(o_rdy[0]), .iAddr(iAddr), .iSize(iSize),
    .iDat(iDat), .iLast(iLast), .oVld(o_vld[0]), .iRdy(iRdy), .oDat(o_dat[0]),
    .oMask(o_mask[0]), .oErr(o_err[0]), .oWordCnt(o_cnt[0])
  );

  zion_dat_write_pack #(.WIDTH_DATA_OUT(32), .WIDTH_UNIT(8), .ADDR_TYPE(1), .WIDTH_CNT(16)) dut1 (
    .clk(clk), .rst(rst), .iVld(iVld), .oRdy(o_rdy[1]), .iAddr(iAddr), .iSize(iSize),
    .iDat(iDat), .iLast(iLast), .oVld(o_vld[1]), .iRdy(iRdy), .oDat(o_dat[1]),
    .oMask(o_mask[1]), .oErr(o_err[1]), .oWordCnt(o_cnt[1])
  );

  // Reference model: per-unit byte arrays in physical lane order
  logic [7:0]  m_buf  [2][4];
  logic        m_bvld [2][4];
  logic        m_ovld [2];
  logic [31:0] m_odat [2];
  logic [3:0]  m_omask[2];
  logic        m_err  [2];
  logic [15:0] m_cnt  [2];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    else passes++;
  endtask

  task automatic modelStep(input int t);
    bit acc, xf, legal, anyv, allv;
    int n, u, lane;
    if (rst) begin
      for (int l = 0; l < 4; l++) begin m_buf[t][l] = 8'h00; m_bvld[t][l] = 1'b0; end
      m_ovld[t] = 1'b0; m_odat[t] = '0; m_omask[t] = '0; m_err[t] = 1'b0; m_cnt[t] = '0;
    end else begin
      acc = iVld && (!m_ovld[t] || iRdy);
      xf  = m_ovld[t] && iRdy;
      m_err[t] = 1'b0;
      if (xf) begin m_cnt[t] = m_cnt[t] + 16'd1; m_ovld[t] = 1'b0; end
      if (acc) begin
        n = 1 << iSize;
        legal = (iSize <= 2) && ((int'(iAddr) % n) == 0);
        if (legal) begin
          for (int k = 0; k < n; k++) begin
            u = int'(iAddr) + k;
            lane = (t == 1) ? 3 - u : u;
            m_buf[t][lane]  = 8'(iDat >> (8 * k));
            m_bvld[t][lane] = 1'b1;
          end
        end else begin
          m_err[t] = 1'b1;
        end
        anyv = 1'b0; allv = 1'b1;
        for (int l = 0; l < 4; l++) begin anyv |= m_bvld[t][l]; allv &= m_bvld[t][l]; end
        if (allv || (iLast && anyv)) begin
          m_ovld[t] = 1'b1;
          for (int l = 0; l < 4; l++) begin
            m_odat[t][8*l +: 8] = m_bvld[t][l] ? m_buf[t][l] : 8'h00;
            m_omask[t][l] = m_bvld[t][l];
            m_buf[t][l] = 8'h00; m_bvld[t][l] = 1'b0;
          end
        end
      end
    end
  endtask

  always @(posedge clk) begin
    modelStep(0);
    modelStep(1);
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int t = 0; t < 2; t++) begin
        checkOutput($sformatf("cycle%0d_dut%0d", cyc, t),
          {9'b0, o_rdy[t], o_vld[t], o_dat[t], o_mask[t], o_err[t], o_cnt[t]},
          {9'b0, !m_ovld[t] || iRdy, m_ovld[t], m_odat[t], m_omask[t], m_err[t], m_cnt[t]});
      end
    end
  end

  task automatic nextCycle();
    @(posedge clk); #1;
  endtask

  task automatic applyStimulus(input logic [1:0] a, input logic [1:0] s,
                               input logic [31:0] d, input logic l);
    int waitCnt = 0;
    iVld = 1'b1; iAddr = a; iSize = s; iDat = d; iLast = l;
    @(negedge clk);
    while (!o_rdy[0] && waitCnt < 20) begin @(negedge clk); waitCnt++; end
    if (!o_rdy[0]) checkOutput("acceptTimeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    iVld = 1'b0; iLast = 1'b0;
  endtask

  task automatic checkWord(input string name, input int t, input logic vld,
                           input logic [31:0] d, input logic [3:0] m);
    checkOutput({name, "_vld"}, 64'(o_vld[t]), 64'(vld));
    checkOutput({name, "_dat"}, 64'(o_dat[t]), 64'(d));
    checkOutput({name, "_mask"}, 64'(o_mask[t]), 64'(m));
  endtask

  initial begin
    nextCycle(); nextCycle();
    rst = 1'b0; chk_en = 1'b1;
    @(negedge clk);
    checkWord("reset", 0, 1'b0, 32'h0, 4'h0);
    checkOutput("reset_err", 64'(o_err[0]), 64'd0);
    checkOutput("reset_cnt", 64'(o_cnt[0]), 64'd0);
    nextCycle();
    iRdy = 1'b1;

    applyStimulus(2'd0, 2'd0, 32'h11, 1'b0);
    applyStimulus(2'd1, 2'd0, 32'h22, 1'b0);
    applyStimulus(2'd2, 2'd0, 32'h33, 1'b0);
    applyStimulus(2'd3, 2'd0, 32'h44, 1'b0);
    @(negedge clk);
    checkWord("bytes", 0, 1'b1, 32'h44332211, 4'hF);
    checkWord("bytes_mirror", 1, 1'b1, 32'h11223344, 4'hF);
    nextCycle(); @(negedge clk);
    checkOutput("bytes_cnt", 64'(o_cnt[0]), 64'd1);
    checkOutput("bytes_vld_drop", 64'(o_vld[0]), 64'd0);
    nextCycle();

    applyStimulus(2'd2, 2'd1, 32'hBEEF, 1'b1);
    @(negedge clk);
    checkWord("half_last", 0, 1'b1, 32'hBEEF0000, 4'b1100);
    checkWord("half_last_mirror", 1, 1'b1, 32'h0000EFBE, 4'b0011);
    nextCycle(); @(negedge clk);
    checkOutput("half_last_pulse", 64'(o_vld[0]), 64'd0);
    nextCycle();

    applyStimulus(2'd0, 2'd0, 32'hAA, 1'b1);
    @(negedge clk);
    checkWord("mirror_byte", 1, 1'b1, 32'hAA000000, 4'b1000);
    checkWord("lsb_byte", 0, 1'b1, 32'h000000AA, 4'b0001);
    nextCycle(); nextCycle();

    applyStimulus(2'd0, 2'd0, 32'h01, 1'b0);
    applyStimulus(2'd1, 2'd1, 32'hFFFF, 1'b0);
    @(negedge clk);
    checkOutput("misalign_err", 64'(o_err[0]), 64'd1);
    nextCycle(); @(negedge clk);
    checkOutput("misalign_err_pulse", 64'(o_err[0]), 64'd0);
    nextCycle();
    applyStimulus(2'd0, 2'd3, 32'hFFFFFFFF, 1'b0);
    @(negedge clk);
    checkOutput("oversize_err", 64'(o_err[0]), 64'd1);
    nextCycle();
    applyStimulus(2'd2, 2'd0, 32'h03, 1'b1);
    @(negedge clk);
    checkWord("after_err", 0, 1'b1, 32'h00030001, 4'b0101);
    nextCycle(); nextCycle();

    applyStimulus(2'd0, 2'd0, 32'h5A, 1'b0);
    applyStimulus(2'd1, 2'd1, 32'h1234, 1'b1);
    @(negedge clk);
    checkWord("bad_last", 0, 1'b1, 32'h0000005A, 4'b0001);
    checkOutput("bad_last_err", 64'(o_err[0]), 64'd1);
    nextCycle(); nextCycle();

    iRdy = 1'b0;
    applyStimulus(2'd0, 2'd2, 32'hCAFEF00D, 1'b0);
    iVld = 1'b1; iAddr = 2'd0; iSize = 2'd2; iDat = 32'h0BADBEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp_rdy", 64'(o_rdy[0]), 64'd0);
      checkWord("bp_hold", 0, 1'b1, 32'hCAFEF00D, 4'hF);
    end
    nextCycle();
    iRdy = 1'b1;
    @(posedge clk); #1;
    iVld = 1'b0;
    @(negedge clk);
    checkWord("bp_release", 0, 1'b1, 32'h0BADBEEF, 4'hF);
    checkOutput("bp_cnt", 64'(o_cnt[0]), 64'd6);
    nextCycle(); nextCycle();

    applyStimulus(2'd0, 2'd0, 32'h77, 1'b0);
    applyStimulus(2'd1, 2'd0, 32'h66, 1'b0);
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    checkWord("mid_reset", 0, 1'b0, 32'h0, 4'h0);
    checkOutput("mid_reset_cnt", 64'(o_cnt[0]), 64'd0);
    nextCycle();
    applyStimulus(2'd0, 2'd2, 32'h12345678, 1'b0);
    @(negedge clk);
    checkWord("post_reset", 0, 1'b1, 32'h12345678, 4'hF);
    checkOutput("post_reset_cnt0", 64'(o_cnt[0]), 64'd0);
    nextCycle(); @(negedge clk);
    checkOutput("post_reset_cnt1", 64'(o_cnt[0]), 64'd1);
    nextCycle();

    for (int i = 0; i < 800; i++) begin
      iVld  = ($urandom_range(0, 9) < 7);
      iSize = 2'($urandom_range(0, 3));
      iAddr = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0 && iSize <= 2)
        iAddr = 2'((int'(iAddr) >> iSize) << iSize);
      iDat  = $urandom;
      iLast = ($urandom_range(0, 7) == 0);
      iRdy  = ($urandom_range(0, 3) != 0);
      nextCycle();
    end
    iVld = 1'b0; iLast = 1'b0; iRdy = 1'b1;
    repeat (4) nextCycle();

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/zion_dat_write_pack.md
Name: zion_dat_write_pack

Overview:
- Write-side counterpart of the multi-width data read selector.
- Accepts narrow writes (1, 2, 4 … units), each with a unit address, and inserts each into the correct lanes of a full-width assembly word. A per-unit valid mask is kept alongside.
- The assembled word is emitted through a registered valid/ready output slot when it is complete or when the producer marks the last write.
- Sits between narrow-beat producers (register/config writers, byte streams) and wide-word consumers (buffers, memories).

Parameters:
- WIDTH_DATA_OUT, 32: output word width; must be a multiple of WIDTH_UNIT.
- WIDTH_UNIT, 8: smallest write granule in bits.
- ADDR_TYPE, 0: lane order. 0 = unit 0 at the LSBs; 1 = unit 0 at the MSBs.
- WIDTH_CNT, 16: width of the completed-word counter.
- Derived (localparams, not overridable):
  - NUM_UNIT = WIDTH_DATA_OUT/WIDTH_UNIT, a power of 2.
  - WIDTH_ADDR = $clog2(NUM_UNIT).
  - WIDTH_SIZE = $clog2(WIDTH_ADDR+1).

Ports:
- clk  input  1  clock; one clock domain.
- rst  input  1  synchronous, active-high reset.
- iVld  input  1  write request valid.
- oRdy  output  1  write request ready.
- iAddr  input  WIDTH_ADDR  unit address of the write.
- iSize  input  WIDTH_SIZE  log2 of the number of units written (0 = 1 unit).
- iDat  input  WIDTH_DATA_OUT  write data, right-aligned; bits above the write size are ignored.
- iLast  input  1  after this write, emit the buffer even if it is partial.
- oVld  output  1  assembled word valid.
- iRdy  input  1  consumer ready.
- oDat  output  WIDTH_DATA_OUT  assembled word.
- oMask  output  NUM_UNIT  units of oDat that were written.
- oErr  output  1  one-cycle pulse: a write was rejected.
- oWordCnt  output  WIDTH_CNT  count of emitted words.

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - Buffer data cleared to 0 and buffer mask cleared to 0.
  - oVld=0, oDat=0, oMask=0, oErr=0, oWordCnt=0.
  - rst overrides any handshake in the same cycle.
- Handshake:
  - oRdy = ~oVld | iRdy, a combinational function of state and iRdy only.
  - A write is accepted when iVld&&oRdy.
  - An output word is transferred when oVld&&iRdy.
  - Accept and transfer may occur in the same cycle.
- Legal write: iSize<=WIDTH_ADDR and iAddr is a multiple of 2^iSize.
  - Merged into the buffer on that cycle's clk edge.
  - Target lanes: units iAddr..iAddr+2^iSize-1, with iDat unit k placed in unit iAddr+k.
  - ADDR_TYPE=1 mirrors the lane index: lane NUM_UNIT-1-u.
  - Rewriting an already-valid unit overwrites it; last write wins, no error.
- Illegal write (misaligned address or oversize):
  - Still accepted (handshake completes).
  - Data and mask unchanged; oErr=1 for the following cycle only.
  - If iLast=1, the buffer is still emitted when nonempty.
- Completion: on an accepted write, let M be the merged mask.
  - If M is all-ones, or iLast=1 and M is nonzero: the output register loads the merged data and M at that edge. The buffer data and mask clear at the same edge.
  - Latency: oVld rises 1 cycle after the completing accept.
  - iLast with an empty merged mask: nothing emitted, no error.
- Output hold: oDat and oMask are stable while oVld=1 and iRdy=0.
  - On transfer with no new completion in the same cycle, oVld=0 next cycle; oDat and oMask keep their old values.
- oWordCnt increments by 1 on each output transfer and wraps to 0 at 2^WIDTH_CNT.
- Back-to-back operation: with iRdy held at 1, one word per cycle is sustainable (NUM_UNIT=1 case, or full-width writes); no bubbles are inserted.

Decomposition:
- Package zion_dat_write_pkg:
  - Function lane_mask(addr, size, ADDR_TYPE) returning the NUM_UNIT-bit unit mask.
  - Function addr_legal(addr, size).
  - WIDTH derivation helpers.
- Sub-module zion_dat_write_merge: purely combinational.
  - Inputs: buffer data and mask, iAddr, iSize, iDat.
  - Outputs: merged data, merged mask, legal flag.
- The top level holds the buffer registers, the output slot, the error pulse and the counter.

Test Plan (WIDTH_DATA_OUT=32, WIDTH_UNIT=8, ADDR_TYPE=0 unless stated):
- Bytes to addr 0,1,2,3 with data 11,22,33,44 h, iRdy=1 -> one cycle after the 4th accept: oVld=1, oDat=32'h44332211, oMask=4'hF; after transfer oWordCnt=1.
- Halfword to addr 2, data 16'hBEEF, iLast=1, empty buffer -> oDat=32'hBEEF0000, oMask=4'b1100, oVld for 1 cycle.
- Backpressure: iRdy=0 while holding 32'hCAFEF00D; a new full-word write presented -> oRdy=0 and oDat stable. Raise iRdy -> transfer, and the new write is accepted in the same cycle.
- Error cases:
  - Halfword to addr 1 -> oErr pulses 1 cycle, oMask unaffected when the word later completes.
  - iSize=3 -> oErr pulses.
  - Misaligned write with iLast=1 on a nonempty buffer -> partial word emitted.
- ADDR_TYPE=1: byte to addr 0, data AA h, iLast=1 -> oDat=32'hAA000000, oMask=4'b1000.
- Reset mid-assembly: bytes to addr 0 and 1, then rst for 1 cycle, then a full word 32'h12345678 -> output exactly 32'h12345678 with oMask=4'hF, and oWordCnt goes 0->1.
